// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - HI/LO sequencing controller for an external multiplier and divider
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        ex_hold,
  input  logic        flush,
  output logic        mul_signed,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_signed,
  output logic        div_annul,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic        stallreq,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata,
  output logic        busy
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        first_q, first_d;

  logic        stall_c, div_start_c, div_annul_c, hi_we_c, lo_we_c;
  logic [31:0] hi_wdata_c, lo_wdata_c;

  assign mul_a      = req_src1;
  assign mul_b      = req_src2;
  assign div_a      = req_src1;
  assign div_b      = req_src2;
  assign mul_signed = (req_op == OP_MULT);
  assign div_signed = (req_op == OP_DIV);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    first_d     = 1'b0;
    stall_c     = 1'b0;
    div_start_c = 1'b0;
    div_annul_c = 1'b0;
    hi_we_c     = 1'b0;
    lo_we_c     = 1'b0;
    hi_wdata_c  = '0;
    lo_wdata_c  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid && !flush) begin
          case (req_op)
            OP_MULT, OP_MULTU: begin
              stall_c = 1'b1;
              cnt_d   = 4'(MUL_LAT - 1);
              state_d = MUL_WAIT;
            end
            OP_DIV, OP_DIVU: begin
              stall_c = 1'b1;
              // Divide by zero never reaches the divider; the result is fixed.
              if (req_src2 != 32'd0) begin
                div_start_c = 1'b1;
                state_d     = DIV_WAIT;
              end else begin
                result_d = {req_src1, 32'hFFFF_FFFF};
                first_d  = 1'b1;
                state_d  = DONE;
              end
            end
            OP_MTHI: begin
              hi_we_c    = 1'b1;
              hi_wdata_c = req_src1;
            end
            OP_MTLO: begin
              lo_we_c    = 1'b1;
              lo_wdata_c = req_src1;
            end
            default: ;
          endcase
        end
      end
      MUL_WAIT: begin
        stall_c = 1'b1;
        if (flush) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          result_d = mul_result;
          first_d  = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DIV_WAIT: begin
        stall_c = 1'b1;
        if (flush) begin
          div_annul_c = 1'b1;
          state_d     = IDLE;
        end else if (div_ready) begin
          result_d = div_result;
          first_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Only the first DONE cycle writes, so a held instruction is not re-committed.
        if (first_q && !flush) begin
          hi_we_c    = 1'b1;
          lo_we_c    = 1'b1;
          hi_wdata_c = result_q[63:32];
          lo_wdata_c = result_q[31:0];
        end
        if (flush || !ex_hold) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Combinational paths from req_* must also be silent while reset is held.
  assign stallreq  = resetn & stall_c;
  assign div_start = resetn & div_start_c;
  assign div_annul = resetn & div_annul_c;
  assign hi_we     = resetn & hi_we_c;
  assign lo_we     = resetn & lo_we_c;
  assign hi_wdata  = resetn ? hi_wdata_c : 32'd0;
  assign lo_wdata  = resetn ? lo_wdata_c : 32'd0;
  assign busy      = resetn & (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - randomized bench for muldiv_ctrl with a cycle-level reference model
module tb_muldiv_ctrl;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn, req_valid, ex_hold, flush;
  logic [2:0]  req_op;
  logic [31:0] req_src1, req_src2;
  logic        mul_signed, div_start, div_signed, div_annul, div_ready;
  logic [31:0] mul_a, mul_b, div_a, div_b;
  logic [63:0] mul_result, div_result;
  logic        stallreq, hi_we, lo_we, busy;
  logic [31:0] hi_wdata, lo_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_op(req_op),
    .req_src1(req_src1), .req_src2(req_src2), .ex_hold(ex_hold), .flush(flush),
    .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
    .div_a(div_a), .div_b(div_b), .div_ready(div_ready), .div_result(div_result),
    .stallreq(stallreq), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mulref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [63:0] ea, eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] divref(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    longint sa, sb, q, r;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Environment: MUL_LAT-stage multiplier and a divider with programmable delay.
  logic [63:0] mpipe [0:MUL_LAT-1];
  logic        s_ms, s_ds, s_dsg, s_da_n;
  logic [31:0] s_ma, s_mb, s_da, s_db;
  logic        dv_busy = 1'b0;
  int          dv_cnt = 0;
  int          div_delay = 1;
  logic [63:0] dv_res = '0;

  assign mul_result = mpipe[MUL_LAT-1];
  assign div_ready  = dv_busy && (dv_cnt == 0);
  assign div_result = dv_res;

  always @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mulref(s_ma, s_mb, s_ms);
    if (!resetn || s_da_n) begin
      dv_busy <= 1'b0;
    end else if (s_ds) begin
      dv_busy <= 1'b1;
      dv_cnt  <= div_delay - 1;
      dv_res  <= divref(s_da, s_db, s_dsg);
    end else if (dv_busy) begin
      if (dv_cnt == 0) dv_busy <= 1'b0;
      else dv_cnt <= dv_cnt - 1;
    end
  end

  // Reference model: mode 0 idle, 1 multiplying, 2 dividing, 3 result ready.
  int          m_mode = 0;
  int          m_left = 0;
  logic        m_first = 1'b0;
  logic [63:0] m_res = '0;

  always @(negedge clk) begin
    logic e_stall, e_busy, e_ds, e_dan, e_hwe, e_lwe;
    logic [31:0] e_hd, e_ld;
    s_ms = mul_signed; s_ma = mul_a; s_mb = mul_b;
    s_ds = div_start; s_dsg = div_signed; s_da = div_a; s_db = div_b; s_da_n = div_annul;
    e_stall = 0; e_busy = 0; e_ds = 0; e_dan = 0; e_hwe = 0; e_lwe = 0; e_hd = 0; e_ld = 0;
    if (!resetn) begin
      m_mode = 0;
      m_first = 0;
    end else begin
      case (m_mode)
        0: if (req_valid && !flush) begin
          if (req_op == 3'd1 || req_op == 3'd2) begin
            e_stall = 1; m_mode = 1; m_left = MUL_LAT;
            m_res = mulref(req_src1, req_src2, req_op == 3'd1);
          end else if (req_op == 3'd3 || req_op == 3'd4) begin
            e_stall = 1;
            if (req_src2 != 0) begin
              e_ds = 1; m_mode = 2;
              m_res = divref(req_src1, req_src2, req_op == 3'd3);
            end else begin
              m_mode = 3; m_first = 1; m_res = {req_src1, 32'hFFFF_FFFF};
            end
          end else if (req_op == 3'd5) begin
            e_hwe = 1; e_hd = req_src1;
          end else if (req_op == 3'd6) begin
            e_lwe = 1; e_ld = req_src1;
          end
        end
        1: begin
          e_busy = 1; e_stall = 1;
          if (flush) m_mode = 0;
          else if (m_left == 1) begin m_mode = 3; m_first = 1; end
          else m_left--;
        end
        2: begin
          e_busy = 1; e_stall = 1;
          if (flush) begin e_dan = 1; m_mode = 0; end
          else if (div_ready) begin m_mode = 3; m_first = 1; end
        end
        default: begin
          e_busy = 1;
          if (m_first && !flush) begin
            e_hwe = 1; e_lwe = 1; e_hd = m_res[63:32]; e_ld = m_res[31:0];
          end
          m_first = 0;
          if (flush || !ex_hold) m_mode = 0;
        end
      endcase
    end
    chk("stallreq", stallreq, e_stall);
    chk("busy", busy, e_busy);
    chk("div_start", div_start, e_ds);
    chk("div_annul", div_annul, e_dan);
    chk("hi_we", hi_we, e_hwe);
    chk("lo_we", lo_we, e_lwe);
    if (e_hwe || !resetn) chk("hi_wdata", hi_wdata, e_hd);
    if (e_lwe || !resetn) chk("lo_wdata", lo_wdata, e_ld);
    chk("mul_a", mul_a, req_src1);
    chk("mul_b", mul_b, req_src2);
    chk("div_a", div_a, req_src1);
    chk("div_b", div_b, req_src2);
    chk("mul_signed", mul_signed, req_op == 3'd1);
    chk("div_signed", div_signed, req_op == 3'd3);
  end

  int r_wait, r_nhw, r_nlw, r_nds, r_nan, r_ndone;
  logic [31:0] r_hd, r_ld;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs the instruction already on req_* like a pipeline would: drop it once it retires or is flushed.
  task automatic run_op(input int maxc, input int hold_n, input int flush_at);
    logic done_seen;
    r_wait = 0; r_nhw = 0; r_nlw = 0; r_nds = 0; r_nan = 0; r_ndone = 0; r_hd = 0; r_ld = 0;
    ex_hold = (hold_n > 0);
    for (int c = 0; c < maxc; c++) begin
      flush = (c == flush_at);
      @(negedge clk);
      if (busy && stallreq) r_wait++;
      if (hi_we) begin r_nhw++; r_hd = hi_wdata; end
      if (lo_we) begin r_nlw++; r_ld = lo_wdata; end
      if (div_start) r_nds++;
      if (div_annul) r_nan++;
      done_seen = busy && !stallreq;
      if (done_seen) r_ndone++;
      tick();
      if ((done_seen && !ex_hold) || flush) req_valid = 0;
      if (r_ndone >= hold_n) ex_hold = 0;
    end
    flush = 0;
    @(negedge clk);
    chk("idle_after_op", busy, 1'b0);
    tick();
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1; req_op = op; req_src1 = a; req_src2 = b;
  endtask

  initial begin
    int nhw;
    for (int i = 0; i < MUL_LAT; i++) mpipe[i] = '0;
    resetn = 0; ex_hold = 0; flush = 0;
    set_req(3'd5, 32'hAAAA_5555, 32'd0);
    @(negedge clk);
    chk("rst_hi_we", hi_we, 1'b0);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_hi_wdata", hi_wdata, 32'd0);
    tick(); tick();
    resetn = 1; req_valid = 0;
    tick();

    set_req(3'd1, 32'hFFFF_FFFE, 32'd3);
    run_op(12, 0, -1);
    chk("mult_wait_cycles", r_wait, MUL_LAT);
    chk("mult_hi_writes", r_nhw, 1);
    chk("mult_lo_writes", r_nlw, 1);
    chk("mult_hi", r_hd, 32'hFFFF_FFFF);
    chk("mult_lo", r_ld, 32'hFFFF_FFFA);

    div_delay = 33;
    set_req(3'd4, 32'd100, 32'd7);
    run_op(45, 0, -1);
    chk("divu_starts", r_nds, 1);
    chk("divu_wait_cycles", r_wait, 33);
    chk("divu_hi", r_hd, 32'd2);
    chk("divu_lo", r_ld, 32'd14);
    chk("divu_writes", r_nhw, 1);

    set_req(3'd3, 32'd5, 32'd0);
    run_op(6, 0, -1);
    chk("div0_starts", r_nds, 0);
    chk("div0_wait_cycles", r_wait, 0);
    chk("div0_done_cycles", r_ndone, 1);
    chk("div0_hi", r_hd, 32'd5);
    chk("div0_lo", r_ld, 32'hFFFF_FFFF);

    set_req(3'd6, 32'h1234, 32'd9);
    @(negedge clk);
    chk("mtlo_lo_we", lo_we, 1'b1);
    chk("mtlo_lo_wdata", lo_wdata, 32'h1234);
    chk("mtlo_stallreq", stallreq, 1'b0);
    chk("mtlo_hi_we", hi_we, 1'b0);
    tick();
    req_valid = 0;

    set_req(3'd3, 32'd50, 32'd3);
    run_op(20, 0, 10);
    chk("flush_annul", r_nan, 1);
    chk("flush_hi_writes", r_nhw, 0);
    chk("flush_lo_writes", r_nlw, 0);

    set_req(3'd2, 32'hFFFF_FFFF, 32'd2);
    run_op(14, 3, -1);
    chk("hold_writes", r_nhw, 1);
    chk("hold_done_cycles", r_ndone, 4);
    chk("hold_hi", r_hd, 32'd1);
    chk("hold_lo", r_ld, 32'hFFFF_FFFE);

    set_req(3'd1, 32'd7, 32'd9);
    tick(); tick();
    resetn = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_stallreq", stallreq, 1'b0);
    tick();
    resetn = 1; req_valid = 0;
    nhw = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (hi_we || lo_we) nhw++;
    end
    chk("midrst_writes", nhw, 0);
    tick();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (m_mode == 0) begin
        req_valid = ($urandom % 4) != 0;
        req_op    = 3'($urandom % 8);
        req_src1  = ($urandom % 2) ? $urandom : ($urandom % 200);
        req_src2  = ($urandom % 4 == 0) ? 32'd0 : (($urandom % 2) ? $urandom : ($urandom % 20));
        div_delay = ($urandom % 10 == 0) ? 33 : 1 + int'($urandom % 12);
      end
      ex_hold = ($urandom % 3) == 0;
      flush   = ($urandom % 20) == 0;
      resetn  = ($urandom % 150) != 0;
      tick();
    end
    resetn = 1; flush = 0; req_valid = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
